// File: rtl/spi_master.sv
// SPI master framing 10-bit command words, with a delayed 8-bit read-back.
// All outputs are registered and derived from the next state.
module spi_master #(
    parameter int unsigned READ_WAIT = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [9:0] cmd_data,
    output logic       busy,
    output logic       done,
    output logic [7:0] rd_data,
    output logic       rd_valid,
    output logic       SS_n,
    output logic       MOSI,
    input  logic       MISO
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SEL   = 3'd1,
        S_CMD   = 3'd2,
        S_SHIFT = 3'd3,
        S_HOLD  = 3'd4,
        S_WAIT  = 3'd5,
        S_RECV  = 3'd6,
        S_END   = 3'd7
    } state_t;

    localparam logic [3:0] WAIT_CYC = 4'(READ_WAIT);

    state_t     state_q, state_d;
    logic [9:0] sr_q, sr_d;
    logic [3:0] cnt_q, cnt_d;
    logic [7:0] rx_q, rx_d;
    logic [7:0] rd_data_q, rd_data_d;
    logic       rd_valid_q, rd_valid_d;
    logic       done_q, done_d;
    logic       busy_q, busy_d;
    logic       ss_n_q, ss_n_d;
    logic       mosi_q, mosi_d;
    logic       is_read;

    assign is_read = (sr_q[9:8] == 2'b11);

    always_comb begin
        state_d    = state_q;
        sr_d       = sr_q;
        cnt_d      = cnt_q;
        rx_d       = rx_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        mosi_d     = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    sr_d    = cmd_data;
                    cnt_d   = 4'd0;
                    rx_d    = 8'h00;
                    state_d = S_SEL;
                end
            end
            S_SEL: begin
                mosi_d  = sr_q[9];
                state_d = S_CMD;
            end
            S_CMD: begin
                mosi_d  = sr_q[9];
                cnt_d   = 4'd10;
                state_d = S_SHIFT;
            end
            S_SHIFT: begin
                if (cnt_q == 4'd1) begin
                    cnt_d   = is_read ? WAIT_CYC : 4'd0;
                    state_d = is_read ? S_WAIT : S_HOLD;
                end else begin
                    // cnt_q counts bits still to send, including the current one
                    cnt_d  = cnt_q - 4'd1;
                    mosi_d = sr_q[cnt_q - 4'd2];
                end
            end
            S_HOLD: begin
                state_d = S_END;
            end
            S_WAIT: begin
                if (cnt_q == 4'd1) begin
                    cnt_d   = 4'd8;
                    state_d = S_RECV;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RECV: begin
                rx_d = {rx_q[6:0], MISO};
                if (cnt_q == 4'd1) begin
                    cnt_d      = 4'd0;
                    rd_data_d  = {rx_q[6:0], MISO};
                    rd_valid_d = 1'b1;
                    state_d    = S_END;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_END: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        ss_n_d = (state_d == S_IDLE) || (state_d == S_END);
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_END);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            sr_q       <= 10'd0;
            cnt_q      <= 4'd0;
            rx_q       <= 8'h00;
            rd_data_q  <= 8'h00;
            rd_valid_q <= 1'b0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
            ss_n_q     <= 1'b1;
            mosi_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            sr_q       <= sr_d;
            cnt_q      <= cnt_d;
            rx_q       <= rx_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            done_q     <= done_d;
            busy_q     <= busy_d;
            ss_n_q     <= ss_n_d;
            mosi_q     <= mosi_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
    assign SS_n     = ss_n_q;
    assign MOSI     = mosi_q;

endmodule

// File: tb/tb_spi_master.sv
// Bench for spi_master: frame-position model, SPI slave with RAM, directed frames.
// Inputs change 1 time unit after posedge; outputs compared on negedge.
module tb_spi_master;

    localparam int RW = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [9:0] cmd_data;
    logic       busy;
    logic       done;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       SS_n;
    logic       MOSI;
    logic       MISO;

    spi_master #(.READ_WAIT(RW)) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .cmd_data(cmd_data),
        .busy(busy),
        .done(done),
        .rd_data(rd_data),
        .rd_valid(rd_valid),
        .SS_n(SS_n),
        .MOSI(MOSI),
        .MISO(MISO)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // Frame-position model: cycle k of a frame (1 = first SS_n-low cycle)
    logic       mv = 1'b0;
    logic       in_f = 1'b0;
    int         k = 0;
    int         flen = 0;
    logic [9:0] f = '0;
    logic [7:0] rx = '0;
    logic [7:0] m_rd = '0;
    logic       e_ss, e_mosi, e_busy, e_done, e_rv;
    logic [7:0] e_rd;

    initial begin
        forever begin
            @(negedge clk);
            if (mv) begin
                chk("ss_n", 32'(SS_n), 32'(e_ss));
                chk("mosi", 32'(MOSI), 32'(e_mosi));
                chk("busy", 32'(busy), 32'(e_busy));
                chk("done", 32'(done), 32'(e_done));
                chk("rd_valid", 32'(rd_valid), 32'(e_rv));
                chk("rd_data", 32'(rd_data), 32'(e_rd));
            end
            if (rst === 1'b1) begin
                mv   = 1'b1;
                in_f = 1'b0;
                k    = 0;
                m_rd = 8'h00;
            end else if (mv) begin
                if (!in_f) begin
                    if (start === 1'b1) begin
                        in_f = 1'b1;
                        f    = cmd_data;
                        k    = 1;
                        rx   = 8'h00;
                        flen = (cmd_data[9:8] == 2'b11) ? 21 + RW : 14;
                    end
                end else begin
                    if (f[9:8] == 2'b11 && k >= 13 + RW && k <= 20 + RW)
                        rx = {rx[6:0], MISO};
                    if (k == flen) begin
                        in_f = 1'b0;
                        k    = 0;
                    end else begin
                        k++;
                    end
                end
            end
            if (!in_f) begin
                e_ss = 1'b1; e_mosi = 1'b0; e_busy = 1'b0;
                e_done = 1'b0; e_rv = 1'b0;
            end else begin
                e_ss   = (k > flen - 1) ? 1'b1 : 1'b0;
                e_mosi = (k == 2) ? f[9] :
                         (k >= 3 && k <= 12) ? f[12 - k] : 1'b0;
                e_busy = 1'b1;
                e_done = (k == flen);
                e_rv   = e_done && (f[9:8] == 2'b11);
                if (e_rv) m_rd = rx;
            end
            e_rd = m_rd;
        end
    end

    // SPI slave with 256-byte RAM; drives MISO, records frame shape
    logic [7:0]  s_ram [256];
    logic [7:0]  s_addr = '0;
    logic [7:0]  s_rdaddr = '0;
    logic [7:0]  s_tx = '0;
    logic [10:0] s_mcap = '0;
    logic [10:0] s_last_mcap = '0;
    int          s_low = 0;
    int          s_high = 0;
    int          s_last_low = 0;
    int          s_last_gap = 0;
    int          s_dones = 0;

    initial begin
        for (int i = 0; i < 256; i++) s_ram[i] = 8'(i);
        s_ram[0] = 8'hC3;
        MISO = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            if (done === 1'b1) s_dones++;
            if (SS_n === 1'b0) begin
                s_low++;
                if (s_low == 1) begin
                    s_last_gap = s_high;
                    s_high = 0;
                    s_mcap = '0;
                    s_tx = s_ram[s_rdaddr];
                end
                if (s_low >= 2 && s_low <= 12) s_mcap = {s_mcap[9:0], MOSI};
                if (s_low >= 13 + RW && s_low <= 20 + RW)
                    MISO = s_tx[20 + RW - s_low];
                else
                    MISO = 1'b0;
            end else begin
                MISO = 1'b0;
                if (s_low > 0) begin
                    s_last_low = s_low;
                    s_last_mcap = s_mcap;
                    if (s_low == 13 || s_low == 20 + RW) begin
                        case (s_mcap[9:8])
                            2'b00: s_addr = s_mcap[7:0];
                            2'b01: s_ram[s_addr] = s_mcap[7:0];
                            2'b10: s_rdaddr = s_mcap[7:0];
                            default: ;
                        endcase
                    end
                end
                s_low = 0;
                s_high++;
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [9:0] c);
        cmd_data = c;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_idle;
        int n = 0;
        while (busy !== 1'b0 && n < 60) begin
            tick();
            n++;
        end
        chk("frame_end", 32'(busy), 32'd0);
    endtask

    int d0;

    initial begin
        rst = 1'b1;
        start = 1'b0;
        cmd_data = '0;
        repeat (3) tick();
        chk("rst_ss_n", 32'(SS_n), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_rd_data", 32'(rd_data), 32'd0);
        chk("rst_mosi", 32'(MOSI), 32'd0);

        start = 1'b1;
        cmd_data = 10'h0A5;
        tick();
        rst = 1'b0;
        start = 1'b0;
        tick();
        chk("start_with_rst", 32'(busy), 32'd0);

        send(10'h0A5);
        wait_idle();
        chk("wa_mosi_bits", 32'(s_last_mcap), 32'h0A5);
        chk("wa_low_len", 32'(s_last_low), 32'd13);
        chk("wa_rd_data", 32'(rd_data), 32'h00);
        tick();

        send(10'h300);
        wait_idle();
        chk("rd_c3", 32'(rd_data), 32'hC3);
        chk("rd_low_len", 32'(s_last_low), 32'd23);
        tick();

        d0 = s_dones;
        send(10'h13C);
        repeat (4) tick();
        cmd_data = 10'h2FF;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_idle();
        chk("busy_start_bits", 32'(s_last_mcap[9:0]), 32'h13C);
        chk("busy_start_dones", 32'(s_dones - d0), 32'd1);
        tick();

        cmd_data = 10'h010;
        start = 1'b1;
        tick();
        cmd_data = 10'h15A;
        repeat (15) tick();
        start = 1'b0;
        wait_idle();
        chk("b2b_gap", 32'(s_last_gap), 32'd2);
        chk("b2b_second_bits", 32'(s_last_mcap[9:0]), 32'h15A);
        tick();

        send(10'h210);
        wait_idle();
        tick();
        send(10'h300);
        wait_idle();
        chk("e2e_rd_data", 32'(rd_data), 32'h5A);
        tick();

        d0 = s_dones;
        send(10'h300);
        repeat (18) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_ss_n", 32'(SS_n), 32'd1);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_rd_data", 32'(rd_data), 32'h00);
        repeat (5) tick();
        chk("midrst_no_done", 32'(s_dones - d0), 32'd0);

        repeat (2) tick();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule

// File: doc/spi_master.md
SPI_MASTER -- requirements
Module: spi_master

Interface
REQ-001 Parameter READ_WAIT, default 3: cycles between the last MOSI bit and the first MISO sample in a read-data frame; legal range 1..15.
REQ-002 clk  input  1  single clock; all logic on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 start  input  1  frame request; sampled only in IDLE.
REQ-005 cmd_data  input  10  frame word; [9:8] command (00 write-addr, 01 write-data, 10 read-addr, 11 read-data), [7:0] payload.
REQ-006 busy  output  1  high from the cycle after start is accepted until done.
REQ-007 done  output  1  one-cycle pulse at frame end.
REQ-008 rd_data  output  8  byte received on MISO in the last read-data frame.
REQ-009 rd_valid  output  1  one-cycle pulse, rd_data updated.
REQ-010 SS_n  output  1  slave select to SPI slave, active low, registered.
REQ-011 MOSI  output  1  serial data to slave, registered.
REQ-012 MISO  input  1  serial data from slave.

Function
REQ-013 FSM states IDLE, SEL, CMD, SHIFT, HOLD, WAIT, RECV, END; 3-bit encoding, binary.
REQ-014 IDLE: SS_n=1, MOSI=0; start=1 -> latch cmd_data into 10-bit shift register, go SEL; start=0 -> stay.
REQ-015 SEL: 1 cycle, SS_n=0, MOSI=0; -> CMD.
REQ-016 CMD: 1 cycle, SS_n=0, MOSI=cmd_data[9]; -> SHIFT, bit counter loaded with 10.
REQ-017 SHIFT: 10 cycles, SS_n=0, MOSI = latched bits [9] down to [0], MSB first, one bit per cycle; counter decrements; after bit 0 -> WAIT if command 11, else HOLD.
REQ-018 HOLD: 1 cycle, SS_n=0, MOSI=0 (gives slave its rx_valid cycle); -> END.
REQ-019 WAIT: READ_WAIT cycles, SS_n=0, MOSI=0, counter counts READ_WAIT down; -> RECV with counter loaded with 8.
REQ-020 RECV: 8 cycles, SS_n=0, MOSI=0; MISO sampled each cycle and shifted in MSB first into an 8-bit receive register; after 8th sample -> END.
REQ-021 END: 1 cycle, SS_n=1, done=1; if frame was command 11, rd_data <= receive register and rd_valid=1 in the same cycle; -> IDLE.
REQ-022 SS_n low duration: exactly 13 cycles for commands 00/01/10; exactly 12+READ_WAIT+8 cycles for command 11.
REQ-023 Minimum SS_n high gap between frames: 2 cycles (END + IDLE).
REQ-024 start while busy is ignored, not queued; cmd_data changes after acceptance have no effect on the frame in progress.
REQ-025 rd_data holds its value until the next completed read-data frame; non-read frames never modify it.
REQ-026 busy=1 in every state except IDLE; busy=0 during END is not allowed (busy falls the cycle after done).
REQ-027 done and rd_valid are never high outside END.

Reset
REQ-028 rst=1 at any clock edge -> next cycle: state IDLE, SS_n=1, MOSI=0, busy=0, done=0, rd_valid=0, rd_data=8'h00, counters and shift registers 0.
REQ-029 rst mid-frame aborts the frame: no done, no rd_valid; SS_n high the cycle after rst sampled.
REQ-030 start asserted together with rst is ignored.

Verification
REQ-031 Write-addr: start, cmd_data=10'h0A5 -> SS_n low 13 cycles; MOSI cycles 2..12 = 0,0,0,1,0,1,0,0,1,0,1; done pulse on cycle 14; rd_valid stays 0.
REQ-032 Read-data, READ_WAIT=3: cmd_data=10'h300, MISO model returns 8'hC3 starting at cycle 16 -> SS_n low 23 cycles; rd_data=8'hC3, rd_valid and done high together in cycle 24.
REQ-033 Back-to-back: start held high continuously -> frames separated by exactly 2 SS_n-high cycles; second cmd_data sampled in IDLE only.
REQ-034 Start while busy: pulse start at cycle 5 of a write frame with different cmd_data -> ignored, frame bits unchanged, single done.
REQ-035 Reset mid-read: rst at RECV cycle 4 -> SS_n=1, busy=0 next cycle; no done/rd_valid; rd_data keeps prior value 8'h00 after reset.
REQ-036 End-to-end: spi_master driving the SPI slave plus RAM: write-addr 8'h10, write-data 8'h5A, read-addr 8'h10, read-data -> rd_data=8'h5A.
